// File: rtl/uart_command_controller_pkg.sv
// Shared constants for the UART command controller: command codes, FSM state
// encoding and the register-file addresses that hold ALU operands.
package uart_command_controller_pkg;

    localparam logic [7:0] CMD_WRITE     = 8'hAA;
    localparam logic [7:0] CMD_READ      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OPS   = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOOPS = 8'hDD;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_WR_ADDR  = 4'd1;
    localparam logic [3:0] ST_WR_DATA  = 4'd2;
    localparam logic [3:0] ST_RD_ADDR  = 4'd3;
    localparam logic [3:0] ST_RD_WAIT  = 4'd4;
    localparam logic [3:0] ST_OP_A     = 4'd5;
    localparam logic [3:0] ST_OP_B     = 4'd6;
    localparam logic [3:0] ST_ALU_FUNC = 4'd7;
    localparam logic [3:0] ST_ALU_WAIT = 4'd8;
    localparam logic [3:0] ST_TX_LO    = 4'd9;
    localparam logic [3:0] ST_TX_HI    = 4'd10;

    localparam int OPERAND_A_ADDR = 0;
    localparam int OPERAND_B_ADDR = 1;

    // States that are waiting on a UART byte; a line error there aborts the command.
    function automatic logic is_collecting(input logic [3:0] st);
        return (st == ST_IDLE)    || (st == ST_WR_ADDR) || (st == ST_WR_DATA) ||
               (st == ST_RD_ADDR) || (st == ST_OP_A)    || (st == ST_OP_B)    ||
               (st == ST_ALU_FUNC);
    endfunction

endpackage

// File: rtl/uart_command_controller_response_serializer.sv
// Holds a read or ALU result and hands it to the UART transmitter one byte at a
// time (low byte first), with a one-cycle tx_valid gap between the two bytes.
module uart_command_controller_response_serializer
    import uart_command_controller_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [2*DATA_WIDTH-1:0] load_data,
    input  logic                    two_bytes,
    input  logic                    tx_busy,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    output logic                    xfer,
    output logic                    last_xfer
);

    logic [2*DATA_WIDTH-1:0] result_q;
    logic                    two_q;
    logic                    hi_q;
    logic                    active_q;
    logic                    valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            two_q    <= 1'b0;
            hi_q     <= 1'b0;
            active_q <= 1'b0;
            valid_q  <= 1'b0;
        end else if (load) begin
            result_q <= load_data;
            two_q    <= two_bytes;
            hi_q     <= 1'b0;
            active_q <= 1'b1;
            valid_q  <= 1'b1;
        end else if (active_q) begin
            if (valid_q && !tx_busy) begin
                valid_q <= 1'b0;
                if (two_q && !hi_q) begin
                    hi_q <= 1'b1;
                end else begin
                    active_q <= 1'b0;
                end
            end else if (!valid_q) begin
                valid_q <= 1'b1;
            end
        end
    end

    assign xfer      = valid_q && !tx_busy;
    assign last_xfer = xfer && (hi_q || !two_q);
    assign tx_valid  = valid_q;
    assign tx_data   = !valid_q ? '0 :
                       hi_q     ? result_q[2*DATA_WIDTH-1:DATA_WIDTH] :
                                  result_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/uart_command_controller.sv
// Command FSM between the UART receiver and the register file / ALU, plus the
// saturating counter of discarded bytes and line errors.
//
//   state     | meaning
//   IDLE      | waiting for a command byte
//   WR_ADDR   | write: waiting for address byte
//   WR_DATA   | write: waiting for data byte, strobes the write
//   RD_ADDR   | read: waiting for address byte, strobes the read
//   RD_WAIT   | read: waiting for rf_read_data_valid
//   OP_A      | ALU: operand A byte -> RF address 0
//   OP_B      | ALU: operand B byte -> RF address 1
//   ALU_FUNC  | ALU: function byte, strobes alu_enable
//   ALU_WAIT  | ALU: waiting for alu_result_valid
//   TX_LO     | sending low response byte
//   TX_HI     | sending high response byte (ALU only)
module uart_command_controller
    import uart_command_controller_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int ALU_FUNC_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_data_valid,
    input  logic [DATA_WIDTH-1:0]     rx_parallel_data,
    input  logic                      rx_parity_error,
    input  logic                      rx_frame_error,
    output logic [ADDR_WIDTH-1:0]     rf_address,
    output logic                      rf_write_enable,
    output logic [DATA_WIDTH-1:0]     rf_write_data,
    output logic                      rf_read_enable,
    input  logic [DATA_WIDTH-1:0]     rf_read_data,
    input  logic                      rf_read_data_valid,
    output logic                      alu_enable,
    output logic [ALU_FUNC_WIDTH-1:0] alu_function,
    input  logic [2*DATA_WIDTH-1:0]   alu_result,
    input  logic                      alu_result_valid,
    output logic [DATA_WIDTH-1:0]     tx_data,
    output logic                      tx_valid,
    input  logic                      tx_busy,
    output logic                      busy,
    output logic [7:0]                dropped_count
);

    logic [3:0]              state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    line_error;
    logic                    collecting;
    logic [3:0]              cmd_next;
    logic                    drop_event;
    logic                    ser_load;
    logic [2*DATA_WIDTH-1:0] ser_data;
    logic                    ser_two;
    logic                    ser_xfer;
    logic                    ser_last;

    always_comb begin
        cmd_next = ST_IDLE;
        if      (rx_parallel_data == DATA_WIDTH'(CMD_WRITE))     cmd_next = ST_WR_ADDR;
        else if (rx_parallel_data == DATA_WIDTH'(CMD_READ))      cmd_next = ST_RD_ADDR;
        else if (rx_parallel_data == DATA_WIDTH'(CMD_ALU_OPS))   cmd_next = ST_OP_A;
        else if (rx_parallel_data == DATA_WIDTH'(CMD_ALU_NOOPS)) cmd_next = ST_ALU_FUNC;
    end

    assign line_error = rx_parity_error || rx_frame_error;
    assign collecting = is_collecting(state_q);

    // At most one count per cycle, even if a byte and an error coincide.
    always_comb begin
        drop_event = 1'b0;
        if (collecting) begin
            drop_event = line_error ||
                         ((state_q == ST_IDLE) && rx_data_valid && (cmd_next == ST_IDLE));
        end else begin
            drop_event = line_error || rx_data_valid;
        end
    end

    assign ser_load = ((state_q == ST_RD_WAIT) && rf_read_data_valid) ||
                      ((state_q == ST_ALU_WAIT) && alu_result_valid);
    assign ser_two  = (state_q == ST_ALU_WAIT);
    assign ser_data = ser_two ? alu_result : {{DATA_WIDTH{1'b0}}, rf_read_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            rf_address      <= '0;
            rf_write_enable <= 1'b0;
            rf_write_data   <= '0;
            rf_read_enable  <= 1'b0;
            alu_enable      <= 1'b0;
            alu_function    <= '0;
            dropped_count   <= '0;
        end else begin
            rf_write_enable <= 1'b0;
            rf_read_enable  <= 1'b0;
            alu_enable      <= 1'b0;
            if (drop_event && (dropped_count != 8'hFF)) begin
                dropped_count <= dropped_count + 8'd1;
            end
            if (collecting && line_error) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: if (rx_data_valid) state_q <= cmd_next;
                    ST_WR_ADDR: if (rx_data_valid) begin
                        addr_q  <= rx_parallel_data[ADDR_WIDTH-1:0];
                        state_q <= ST_WR_DATA;
                    end
                    ST_WR_DATA: if (rx_data_valid) begin
                        rf_write_enable <= 1'b1;
                        rf_address      <= addr_q;
                        rf_write_data   <= rx_parallel_data;
                        state_q         <= ST_IDLE;
                    end
                    ST_RD_ADDR: if (rx_data_valid) begin
                        rf_read_enable <= 1'b1;
                        rf_address     <= rx_parallel_data[ADDR_WIDTH-1:0];
                        state_q        <= ST_RD_WAIT;
                    end
                    ST_RD_WAIT: if (rf_read_data_valid) state_q <= ST_TX_LO;
                    ST_OP_A: if (rx_data_valid) begin
                        rf_write_enable <= 1'b1;
                        rf_address      <= ADDR_WIDTH'(OPERAND_A_ADDR);
                        rf_write_data   <= rx_parallel_data;
                        state_q         <= ST_OP_B;
                    end
                    ST_OP_B: if (rx_data_valid) begin
                        rf_write_enable <= 1'b1;
                        rf_address      <= ADDR_WIDTH'(OPERAND_B_ADDR);
                        rf_write_data   <= rx_parallel_data;
                        state_q         <= ST_ALU_FUNC;
                    end
                    ST_ALU_FUNC: if (rx_data_valid) begin
                        alu_enable   <= 1'b1;
                        alu_function <= rx_parallel_data[ALU_FUNC_WIDTH-1:0];
                        state_q      <= ST_ALU_WAIT;
                    end
                    ST_ALU_WAIT: if (alu_result_valid) state_q <= ST_TX_LO;
                    ST_TX_LO: begin
                        if (ser_last)      state_q <= ST_IDLE;
                        else if (ser_xfer) state_q <= ST_TX_HI;
                    end
                    ST_TX_HI: if (ser_xfer) state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy = (state_q != ST_IDLE);

    uart_command_controller_response_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_response_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .load_data (ser_data),
        .two_bytes (ser_two),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .xfer      (ser_xfer),
        .last_xfer (ser_last)
    );

endmodule

// File: tb/tb_uart_command_controller.sv
// Directed bench for uart_command_controller: write, read with back-pressure,
// ALU with/without operands, line errors, reset mid-command, counter saturation.
module tb_uart_command_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_data_valid = 1'b0;
    logic [7:0]  rx_parallel_data = 8'h00;
    logic        rx_parity_error = 1'b0;
    logic        rx_frame_error = 1'b0;
    logic [3:0]  rf_address;
    logic        rf_write_enable;
    logic [7:0]  rf_write_data;
    logic        rf_read_enable;
    logic [7:0]  rf_read_data = 8'h00;
    logic        rf_read_data_valid = 1'b0;
    logic        alu_enable;
    logic [3:0]  alu_function;
    logic [15:0] alu_result = 16'h0000;
    logic        alu_result_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy = 1'b0;
    logic        busy;
    logic [7:0]  dropped_count;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int alu_cnt = 0;
    int stab_viol = 0;
    int gap_viol = 0;
    logic [3:0] wr_addr_log[$];
    logic [7:0] wr_data_log[$];
    logic [7:0] tx_q[$];
    logic       prev_tv = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [15:0] popped;

    uart_command_controller #(
        .DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUNC_WIDTH(4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .rx_data_valid      (rx_data_valid),
        .rx_parallel_data   (rx_parallel_data),
        .rx_parity_error    (rx_parity_error),
        .rx_frame_error     (rx_frame_error),
        .rf_address         (rf_address),
        .rf_write_enable    (rf_write_enable),
        .rf_write_data      (rf_write_data),
        .rf_read_enable     (rf_read_enable),
        .rf_read_data       (rf_read_data),
        .rf_read_data_valid (rf_read_data_valid),
        .alu_enable         (alu_enable),
        .alu_function       (alu_function),
        .alu_result         (alu_result),
        .alu_result_valid   (alu_result_valid),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_busy            (tx_busy),
        .busy               (busy),
        .dropped_count      (dropped_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; observers look at the falling edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data_valid    = 1'b1;
        rx_parallel_data = b;
        step(1);
        rx_data_valid    = 1'b0;
    endtask

    task automatic pop_tx(output logic [15:0] b);
        if (tx_q.size() > 0) b = {8'h00, tx_q.pop_front()};
        else                 b = 16'hDEAD;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rf_write_enable) begin
                wr_cnt++;
                wr_addr_log.push_back(rf_address);
                wr_data_log.push_back(rf_write_data);
            end
            if (rf_read_enable) rd_cnt++;
            if (alu_enable) alu_cnt++;
            if (prev_tv && prev_busy && !(tx_valid && tx_data == prev_data)) stab_viol++;
            if (prev_tv && !prev_busy && tx_valid) gap_viol++;
            if (tx_valid && !tx_busy) tx_q.push_back(tx_data);
        end
        prev_tv   = tx_valid;
        prev_busy = tx_busy;
        prev_data = tx_data;
    end

    initial begin
        // reset state
        step(3);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_dropped", dropped_count, 0);
        check("rst_strobes", {rf_write_enable, rf_read_enable, alu_enable, tx_valid}, 0);
        check("rst_data", {rf_address, rf_write_data, alu_function, tx_data}, 0);
        step(1);
        reset = 1'b0;
        step(2);

        // write AA,05,3C
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h3C);
        @(negedge clk);
        check("wr_strobe", rf_write_enable, 1);
        check("wr_addr", rf_address, 4'h5);
        check("wr_data", rf_write_data, 8'h3C);
        step(3);
        @(negedge clk);
        check("wr_count", wr_cnt, 1);
        check("wr_no_tx", tx_q.size(), 0);
        check("wr_busy", busy, 0);

        // read BB,05 with transmitter back-pressure
        tx_busy = 1'b1;
        send_byte(8'hBB);
        send_byte(8'h05);
        @(negedge clk);
        check("rd_strobe", rf_read_enable, 1);
        check("rd_addr", rf_address, 4'h5);
        step(2);
        rf_read_data       = 8'h3C;
        rf_read_data_valid = 1'b1;
        step(1);
        rf_read_data_valid = 1'b0;
        @(negedge clk);
        check("rd_tx_valid", tx_valid, 1);
        check("rd_tx_data", tx_data, 8'h3C);
        step(8);
        @(negedge clk);
        check("rd_tx_held", {tx_valid, tx_data}, {1'b1, 8'h3C});
        check("rd_no_xfer_yet", tx_q.size(), 0);
        tx_busy = 1'b0;
        step(4);
        @(negedge clk);
        check("rd_xfer_count", tx_q.size(), 1);
        pop_tx(popped);
        check("rd_xfer_byte", popped, 16'h003C);
        check("rd_count", rd_cnt, 1);
        check("rd_busy", busy, 0);

        // ALU with operands CC,12,34,02 -> 0x0246
        send_byte(8'hCC);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h02);
        @(negedge clk);
        check("alu_strobe", alu_enable, 1);
        check("alu_func", alu_function, 4'h2);
        check("alu_wr_count", wr_cnt, 3);
        check("alu_op_a", {wr_addr_log[1], wr_data_log[1]}, {4'h0, 8'h12});
        check("alu_op_b", {wr_addr_log[2], wr_data_log[2]}, {4'h1, 8'h34});
        step(1);
        alu_result       = 16'h0246;
        alu_result_valid = 1'b1;
        step(1);
        alu_result_valid = 1'b0;
        step(6);
        @(negedge clk);
        check("alu_tx_count", tx_q.size(), 2);
        pop_tx(popped);
        check("alu_tx_lo", popped, 16'h0046);
        pop_tx(popped);
        check("alu_tx_hi", popped, 16'h0002);
        check("alu_busy", busy, 0);

        // ALU without operands DD,01, stray 0x77 during ALU_WAIT
        send_byte(8'hDD);
        send_byte(8'h01);
        @(negedge clk);
        check("alu2_func", {alu_enable, alu_function}, {1'b1, 4'h1});
        step(1);
        send_byte(8'h77);
        step(1);
        alu_result       = 16'h1234;
        alu_result_valid = 1'b1;
        step(1);
        alu_result_valid = 1'b0;
        step(6);
        @(negedge clk);
        check("alu2_dropped", dropped_count, 1);
        check("alu2_tx_count", tx_q.size(), 2);
        pop_tx(popped);
        check("alu2_tx_lo", popped, 16'h0034);
        pop_tx(popped);
        check("alu2_tx_hi", popped, 16'h0012);
        check("alu2_count", alu_cnt, 2);

        // frame error aborts a write; stray bytes in IDLE are counted
        send_byte(8'hAA);
        send_byte(8'h05);
        rx_frame_error = 1'b1;
        step(1);
        rx_frame_error = 1'b0;
        step(2);
        @(negedge clk);
        check("ferr_busy", busy, 0);
        check("ferr_dropped", dropped_count, 2);
        send_byte(8'h55);
        send_byte(8'h3C);
        step(2);
        @(negedge clk);
        check("stray_dropped", dropped_count, 4);
        check("ferr_no_write", wr_cnt, 3);
        // command byte coinciding with a parity error is discarded once
        rx_parity_error = 1'b1;
        send_byte(8'hAA);
        rx_parity_error = 1'b0;
        @(negedge clk);
        check("perr_busy", busy, 0);
        check("perr_dropped", dropped_count, 5);

        // reset during RD_WAIT
        send_byte(8'hBB);
        send_byte(8'h03);
        step(1);
        @(negedge clk);
        check("rst2_pre_busy", busy, 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clk);
        check("rst2_busy", busy, 0);
        check("rst2_dropped", dropped_count, 0);
        check("rst2_outs", {rf_write_enable, rf_read_enable, alu_enable, tx_valid, rf_address}, 0);
        step(1);
        // reset on the completing byte: no strobe afterwards
        send_byte(8'hAA);
        send_byte(8'h01);
        reset = 1'b1;
        send_byte(8'hFF);
        reset = 1'b0;
        @(negedge clk);
        check("rst3_no_strobe", {rf_write_enable, busy}, 0);
        step(1);
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'hFF);
        @(negedge clk);
        check("post_rst_wr", {rf_write_enable, rf_address, rf_write_data}, {1'b1, 4'h1, 8'hFF});
        step(2);
        @(negedge clk);
        check("post_rst_count", wr_cnt, 4);
        check("post_rst_rd_count", rd_cnt, 2);

        // saturation: 260 stray bytes
        rx_data_valid    = 1'b1;
        rx_parallel_data = 8'h55;
        step(260);
        rx_data_valid    = 1'b0;
        step(1);
        @(negedge clk);
        check("sat_dropped", dropped_count, 8'hFF);
        check("sat_busy", busy, 0);

        check("tx_stability", stab_viol, 0);
        check("tx_gap", gap_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
